seven_seg_scan_shifter: RTL
===========================

# seven_seg_scan_shifter

Parametrised multi-digit seven-segment scanner with an integrated serial shift-out engine. It holds a double-buffered hex value with per-digit decimal point and blank controls, plus optional leading-zero suppression. It time-multiplexes one digit at a time and serialises a 16-bit {digit-select, segments} word to an external 74HC595-style shift-register chain. It sits between application logic, which supplies the value, and the board pins that carry data, shift clock and latch.

## Interface
- NUM_DIGITS, 3: digit count, legal range 1..8.
- SHIFT_DIV, 2: CLK cycles per shift-clock half period, ≥1.
- DWELL_CYCLES, 16000: target CLK cycles per digit slot.
- SEG_ACTIVE_LOW, 0: 1 inverts the 8 segment bits.
- DIG_ACTIVE_LOW, 0: 1 inverts the 8 digit-select bits.
- CLK  in  1  system clock; the only clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_digits  in  4*NUM_DIGITS  hex nibbles; digit d is [4d+3:4d], and digit 0 is the rightmost.
- i_dp  in  NUM_DIGITS  per-digit decimal point enable.
- i_blank  in  NUM_DIGITS  per-digit force-blank.
- i_lzs  in  1  leading-zero suppression enable.
- i_load  in  1  captures i_digits, i_dp, i_blank and i_lzs into the shadow register.
- o_sh_ds  out  1  serial data.
- o_sh_clk  out  1  shift clock; the external device samples on its rising edge.
- o_sh_latch  out  1  storage latch pulse.
- o_digit  out  3  index of the digit currently shown.
- o_frame_done  out  1  one-cycle pulse after the last digit of a frame latches.

## Operation
- **Buffering.**
  - i_load=1 writes the shadow register that cycle.
  - The shadow register is copied to the active register on entry to LOAD for digit 0 only, so a displayed frame is never torn.
  - Reset clears both registers to 0.
- **Decode.**
  - Segment bits are {dp,g,f,e,d,c,b,a}, with a as bit 0.
  - Hex patterns 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - dp sets bit 7.
- **Blanking.** The segment byte is 0x00 (before inversion) when any of these hold:
  - i_blank[d] is set.
  - Leading-zero suppression applies: i_lzs=1, d>0, and nibble d and every higher nibble are 0.
  - A set dp on digit d, or on any higher digit, cancels suppression for digit d and every lower digit.
  - Digit 0 is never suppressed.
- **Word.**
  - The word is {sel[7:0], seg[7:0]}.
  - sel has only bit d set; unused bits are 0.
  - Inversion parameters are applied last.
  - The word is shifted MSB first.
- **States.**
  - LOAD, 1 cycle: form the word for o_digit; bit index=15; start the slot counter.
  - SHIFT_LO, SHIFT_DIV cycles: o_sh_ds=word[bit]; o_sh_clk=0.
  - SHIFT_HI, SHIFT_DIV cycles: o_sh_clk=1, with o_sh_ds held. On exit, go to LATCH if bit==0; otherwise decrement bit and go to SHIFT_LO.
  - LATCH, SHIFT_DIV cycles: o_sh_latch=1, o_sh_clk=0.
  - DWELL: hold all outputs low until the slot counter reaches max(DWELL_CYCLES, 2+33*SHIFT_DIV)−1.
    - Then o_digit wraps to 0 after NUM_DIGITS−1; otherwise it increments.
    - The next state is LOAD.
    - DWELL always lasts at least 1 cycle.
- **Frame done.** o_frame_done pulses in the first DWELL cycle of digit NUM_DIGITS−1.
- **Loads and reset.**
  - i_load in the same cycle as the digit-0 LOAD is visible in that frame, through a shadow-write bypass.
  - i_reset_n=0 at any point, including mid-shift, aborts the transfer.
  - No partial latch is ever issued after reset.

## Timing
- **Reset values.**
  - o_sh_ds, o_sh_clk, o_sh_latch and o_frame_done are 0.
  - o_digit is 0.
  - The state is LOAD with digit 0, entered on the first cycle after i_reset_n goes high.
- **Per-digit phases.** Shift-out plus latch takes 1+33*SHIFT_DIV cycles. The slot period is max(DWELL_CYCLES, 2+33*SHIFT_DIV) cycles.
- **Frame period.** NUM_DIGITS × the slot period.
- **Load latency.** From i_load to first appearance on pins: up to one frame plus LOAD+SHIFT time.
- **Edge spacing.**
  - The first rising edge of o_sh_clk occurs SHIFT_DIV cycles after the first data bit is driven.
  - o_sh_ds changes only while o_sh_clk=0.
  - o_sh_latch never overlaps o_sh_clk=1.

## Test plan
All cases use NUM_DIGITS=3, SHIFT_DIV=2 and DWELL_CYCLES=100 unless noted; the slot period is therefore 100.

- Reset, then load i_digits=0x1A3 with i_dp=0 and i_blank=0.
  - Digit 0 word 0x014F: capture o_sh_ds on 16 o_sh_clk rising edges, then one latch of 2 cycles.
- Free run.
  - Words follow the sequence 0x014F, 0x0277, 0x0406, repeating.
  - o_frame_done recurs every 300 cycles.
  - o_digit runs 0,1,2,0.
- Load 0x7FF during the digit-1 slot.
  - Digits 1 and 2 still show 0x0277 and 0x0406.
  - The next digit 0 shows 0x0171.
- Leading-zero suppression with i_lzs=1 and value 0x005.
  - Words are 0x016D, 0x0200, 0x0400.
  - Adding i_dp=3'b010 changes digit 1 to 0x02BF.
- Assert i_reset_n=0 at bit 7 of the digit-1 shift.
  - All outputs are 0 the next cycle, with no latch pulse.
  - The restart begins at digit 0 showing 0x0100|0x3F, because the registers are cleared.
- SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1 with digit 0 value 8: the word is 0xFE80.

Source files
------------

// File: rtl/seven_seg_scan_shifter.sv
// Multiplexed seven-segment scanner. It forms one {digit-select, segments} word per
// digit slot and shifts that word MSB first into a 74HC595-style chain, then latches it.
module seven_seg_scan_shifter #(
   parameter int NUM_DIGITS     = 3,
   parameter int SHIFT_DIV      = 2,
   parameter int DWELL_CYCLES   = 16000,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                    CLK,
   input  logic                    i_reset_n,
   input  logic [4*NUM_DIGITS-1:0] i_digits,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   input  logic                    i_lzs,
   input  logic                    i_load,
   output logic                    o_sh_ds,
   output logic                    o_sh_clk,
   output logic                    o_sh_latch,
   output logic [2:0]              o_digit,
   output logic                    o_frame_done
);

   localparam int MIN_SLOT = 2 + 33 * SHIFT_DIV;
   localparam int SLOT     = (DWELL_CYCLES > MIN_SLOT) ? DWELL_CYCLES : MIN_SLOT;
   localparam int SW       = $clog2(SLOT);
   localparam int PW       = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

   localparam logic [PW-1:0] PHASE_LAST  = PW'(SHIFT_DIV - 1);
   localparam logic [SW-1:0] SLOT_LAST   = SW'(SLOT - 1);
   localparam logic [SW-1:0] FIRST_DWELL = SW'(1 + 33 * SHIFT_DIV);
   localparam logic [2:0]    DIGIT_LAST  = 3'(NUM_DIGITS - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LATCH,
      S_DWELL
   } state_t;

   state_t                  state, state_next;
   logic [PW-1:0]           phase;
   logic [3:0]              bit_idx;
   logic [SW-1:0]           slot_cnt;
   logic [2:0]              digit;
   logic [15:0]             word, word_next;
   logic                    phase_end, slot_end;

   logic [4*NUM_DIGITS-1:0] sh_digits, act_digits, src_digits;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp, src_dp;
   logic [NUM_DIGITS-1:0]   sh_blank, act_blank, src_blank;
   logic                    sh_lzs, act_lzs, src_lzs;

   function automatic logic [6:0] seg_hex(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // zero_run stays set while every nibble from the top down to i is zero with no dp,
   // which is exactly the condition under which digit i may be suppressed.
   function automatic logic [15:0] make_word(
      input logic [4*NUM_DIGITS-1:0] v,
      input logic [NUM_DIGITS-1:0]   dp,
      input logic [NUM_DIGITS-1:0]   blank,
      input logic                    lzs,
      input logic [2:0]              d
   );
      logic [3:0] nib;
      logic       dp_d, blank_d, zero_run, sup;
      logic [7:0] seg, sel;
      nib      = 4'h0;
      dp_d     = 1'b0;
      blank_d  = 1'b0;
      zero_run = 1'b1;
      sup      = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (v[4*i +: 4] == 4'h0) & ~dp[i];
         if (d == 3'(i)) begin
            nib     = v[4*i +: 4];
            dp_d    = dp[i];
            blank_d = blank[i];
            sup     = lzs & zero_run & (i != 0);
         end
      end
      seg = (blank_d | sup) ? 8'h00 : {dp_d, seg_hex(nib)};
      sel = 8'h01 << d;
      return {sel ^ {8{DIG_ACTIVE_LOW}}, seg ^ {8{SEG_ACTIVE_LOW}}};
   endfunction

   assign phase_end = (phase == PHASE_LAST);
   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign o_digit   = digit;

   // Digit 0 reads the shadow (or the bypassed input) so a new frame starts atomically.
   always_comb begin
      src_digits = act_digits;
      src_dp     = act_dp;
      src_blank  = act_blank;
      src_lzs    = act_lzs;
      if (digit == 3'd0) begin
         if (i_load) begin
            src_digits = i_digits;
            src_dp     = i_dp;
            src_blank  = i_blank;
            src_lzs    = i_lzs;
         end else begin
            src_digits = sh_digits;
            src_dp     = sh_dp;
            src_blank  = sh_blank;
            src_lzs    = sh_lzs;
         end
      end
      word_next = make_word(src_digits, src_dp, src_blank, src_lzs, digit);
   end

   always_comb begin
      state_next   = state;
      o_sh_ds      = 1'b0;
      o_sh_clk     = 1'b0;
      o_sh_latch   = 1'b0;
      o_frame_done = 1'b0;
      unique case (state)
         S_LOAD: state_next = S_SHIFT_LO;
         S_SHIFT_LO: begin
            o_sh_ds = word[bit_idx];
            if (phase_end) state_next = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            o_sh_ds  = word[bit_idx];
            o_sh_clk = 1'b1;
            if (phase_end) state_next = (bit_idx == 4'd0) ? S_LATCH : S_SHIFT_LO;
         end
         S_LATCH: begin
            o_sh_latch = 1'b1;
            if (phase_end) state_next = S_DWELL;
         end
         S_DWELL: begin
            o_frame_done = (slot_cnt == FIRST_DWELL) && (digit == DIGIT_LAST);
            if (slot_end) state_next = S_LOAD;
         end
         default: state_next = S_LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!i_reset_n) begin
         state      <= S_LOAD;
         phase      <= '0;
         bit_idx    <= 4'd15;
         slot_cnt   <= '0;
         digit      <= 3'd0;
         word       <= 16'h0000;
         sh_digits  <= '0;
         sh_dp      <= '0;
         sh_blank   <= '0;
         sh_lzs     <= 1'b0;
         act_digits <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         act_lzs    <= 1'b0;
      end else begin
         state    <= state_next;
         phase    <= (state_next != state) ? '0 : phase + 1'b1;
         slot_cnt <= (state == S_LOAD) ? SW'(1) : slot_cnt + 1'b1;
         if (i_load) begin
            sh_digits <= i_digits;
            sh_dp     <= i_dp;
            sh_blank  <= i_blank;
            sh_lzs    <= i_lzs;
         end
         case (state)
            S_LOAD: begin
               word    <= word_next;
               bit_idx <= 4'd15;
               if (digit == 3'd0) begin
                  act_digits <= src_digits;
                  act_dp     <= src_dp;
                  act_blank  <= src_blank;
                  act_lzs    <= src_lzs;
               end
            end
            S_SHIFT_HI: if (phase_end && bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
            S_DWELL:    if (slot_end) digit <= (digit == DIGIT_LAST) ? 3'd0 : digit + 3'd1;
            default: ;
         endcase
      end
   end

endmodule
